panel_selector: RTL and testbench

Front-panel selection controller for the 6x2 antenna switch. Debounces the twelve panel push-buttons (six per radio port), turns presses into one-hot antenna selections for switch A and switch B, and flags an A/B collision on the same antenna. Sits directly upstream of the output latch stage and drives its data, collision and falling-edge load-strobe inputs with a fixed setup/strobe/hold sequence.

---
 rtl/panel_selector.sv | 273 +++++++++++++++++++++++++++
 tb/tb_panel_selector.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/panel_selector.sv
// panel_selector
// Front-panel selection controller for the 6x2 antenna switch.
// Debounces twelve panel buttons (six per radio port). Each accepted press
// becomes a one-hot antenna request. Every request is presented to the
// downstream output latch with a fixed setup / strobe / hold sequence, and
// the latch captures on the falling edge of O_load.
//
// Ports:
//   I_clk        system clock (single clock domain)
//   I_rst        synchronous reset, active-high
//   I_btn_A[5:0] raw panel buttons, switch A (async, HIGH = pressed)
//   I_btn_B[5:0] raw panel buttons, switch B (async, HIGH = pressed)
//   I_remote     HIGH = remote control active, panel presses discarded
//   O_A[5:0]     switch A selection presented to the latch
//   O_B[5:0]     switch B selection presented to the latch
//   O_load       load strobe, consumer captures on falling edge
//   O_collision  HIGH while the presented pair selects the same antenna
//   O_busy       HIGH whenever the sequencer is not idle
//
// Build option:
//   PANEL_DESELECT_EN  when defined, pressing the already selected antenna
//                      deselects that side (drives 0) through a normal
//                      sequence. When undefined, such a press is ignored.
module panel_selector #(
  parameter int DEBOUNCE_CYCLES = 20000,
  parameter int LOAD_CYCLES     = 4
) (
  input  logic       I_clk,
  input  logic       I_rst,
  input  logic [5:0] I_btn_A,
  input  logic [5:0] I_btn_B,
  input  logic       I_remote,
  output logic [5:0] O_A,
  output logic [5:0] O_B,
  output logic       O_load,
  output logic       O_collision,
  output logic       O_busy
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam int LW = (LOAD_CYCLES > 1) ? $clog2(LOAD_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;

  // Isolate the lowest set bit, so the lowest index wins among simultaneous presses.
  function automatic logic [5:0] lowest_one(input logic [5:0] v);
    return v & (~v + 6'd1);
  endfunction

  logic [11:0]   btn;
  logic [11:0]   sync1;
  logic [11:0]   sync2;
  logic [11:0]   deb;
  logic [CW-1:0] cnt [12];
  logic [11:0]   press;
  logic [5:0]    ev_a;
  logic [5:0]    ev_b;

  logic [5:0]    pend_a;
  logic [5:0]    pend_b;
  logic          pend_a_v;
  logic          pend_b_v;
  logic          take_a;
  logic          take_b;

  state_t        state;
  state_t        state_next;
  logic [LW-1:0] ld_cnt;
  logic [LW-1:0] ld_cnt_next;
  logic [5:0]    cand_a;
  logic [5:0]    cand_b;
  logic [5:0]    cand_a_next;
  logic [5:0]    cand_b_next;
  logic [5:0]    sel_a;
  logic [5:0]    sel_b;
  logic [5:0]    sel_a_next;
  logic [5:0]    sel_b_next;
  logic          cand_coll;

  assign btn = {I_btn_B, I_btn_A};

  // Two-flop synchroniser and per-button debounce counter.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      sync1 <= 12'd0;
      sync2 <= 12'd0;
      deb   <= 12'd0;
      for (int i = 0; i < 12; i++) begin
        cnt[i] <= {CW{1'b0}};
      end
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      for (int i = 0; i < 12; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= {CW{1'b0}};
        end else if (cnt[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          deb[i] <= ~deb[i];
          cnt[i] <= {CW{1'b0}};
        end else begin
          cnt[i] <= cnt[i] + CW'(1);
        end
      end
    end
  end

  // A press event is the cycle in which a low debounced level is about to toggle high.
  always_comb begin
    press = 12'd0;
    for (int i = 0; i < 12; i++) begin
      if (sync2[i] && !deb[i] && (cnt[i] == CW'(DEBOUNCE_CYCLES - 1))) begin
        press[i] = 1'b1;
      end else begin
        press[i] = 1'b0;
      end
    end
  end

  assign ev_a = lowest_one(press[5:0]);
  assign ev_b = lowest_one(press[11:6]);

  // Pending request per side. A new event overwrites the request. Remote mode flushes it.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      pend_a   <= 6'd0;
      pend_b   <= 6'd0;
      pend_a_v <= 1'b0;
      pend_b_v <= 1'b0;
    end else begin
      if (I_remote) begin
        pend_a_v <= 1'b0;
      end else if (ev_a != 6'd0) begin
        pend_a   <= ev_a;
        pend_a_v <= 1'b1;
      end else if (take_a) begin
        pend_a_v <= 1'b0;
      end else begin
        pend_a_v <= pend_a_v;
      end
      if (I_remote) begin
        pend_b_v <= 1'b0;
      end else if (ev_b != 6'd0) begin
        pend_b   <= ev_b;
        pend_b_v <= 1'b1;
      end else if (take_b) begin
        pend_b_v <= 1'b0;
      end else begin
        pend_b_v <= pend_b_v;
      end
    end
  end

  assign cand_coll = |(cand_a & cand_b);

  // Sequencer next-state and datapath. A pending request has priority over B.
  always_comb begin
    state_next  = state;
    ld_cnt_next = ld_cnt;
    cand_a_next = cand_a;
    cand_b_next = cand_b;
    sel_a_next  = sel_a;
    sel_b_next  = sel_b;
    take_a      = 1'b0;
    take_b      = 1'b0;
    case (state)
      IDLE: begin
        if (pend_a_v && !I_remote) begin
          take_a = 1'b1;
`ifdef PANEL_DESELECT_EN
          cand_a_next = (pend_a == sel_a) ? 6'd0 : pend_a;
          cand_b_next = sel_b;
          state_next  = SETUP;
`else
          // A re-press of the current antenna is consumed without a sequence.
          if (pend_a == sel_a) begin
            state_next = IDLE;
          end else begin
            cand_a_next = pend_a;
            cand_b_next = sel_b;
            state_next  = SETUP;
          end
`endif
        end else if (pend_b_v && !I_remote) begin
          take_b = 1'b1;
`ifdef PANEL_DESELECT_EN
          cand_b_next = (pend_b == sel_b) ? 6'd0 : pend_b;
          cand_a_next = sel_a;
          state_next  = SETUP;
`else
          if (pend_b == sel_b) begin
            state_next = IDLE;
          end else begin
            cand_b_next = pend_b;
            cand_a_next = sel_a;
            state_next  = SETUP;
          end
`endif
        end else begin
          state_next = IDLE;
        end
      end
      SETUP: begin
        ld_cnt_next = {LW{1'b0}};
        state_next  = STROBE;
      end
      STROBE: begin
        if (ld_cnt == LW'(LOAD_CYCLES - 1)) begin
          state_next = HOLD;
        end else begin
          ld_cnt_next = ld_cnt + LW'(1);
          state_next  = STROBE;
        end
      end
      HOLD: begin
        // The latch rejects a collided pair, so the committed view stays as it was.
        if (!cand_coll) begin
          sel_a_next = cand_a;
          sel_b_next = cand_b;
        end else begin
          sel_a_next = sel_a;
          sel_b_next = sel_b;
        end
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Sequencer state, candidate and committed-selection registers.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state  <= IDLE;
      ld_cnt <= {LW{1'b0}};
      cand_a <= 6'd0;
      cand_b <= 6'd0;
      sel_a  <= 6'd0;
      sel_b  <= 6'd0;
    end else begin
      state  <= state_next;
      ld_cnt <= ld_cnt_next;
      cand_a <= cand_a_next;
      cand_b <= cand_b_next;
      sel_a  <= sel_a_next;
      sel_b  <= sel_b_next;
    end
  end

  // Outputs are registered from the next-state values so that they line up with the state.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      O_A         <= 6'd0;
      O_B         <= 6'd0;
      O_load      <= 1'b0;
      O_collision <= 1'b0;
      O_busy      <= 1'b0;
    end else begin
      O_busy <= (state_next != IDLE);
      O_load <= (state_next == STROBE);
      if (state_next == IDLE) begin
        O_A         <= sel_a_next;
        O_B         <= sel_b_next;
        O_collision <= 1'b0;
      end else begin
        O_A         <= cand_a_next;
        O_B         <= cand_b_next;
        O_collision <= |(cand_a_next & cand_b_next);
      end
    end
  end

endmodule

// File: tb/tb_panel_selector.sv
// Self-checking bench for panel_selector with DEBOUNCE_CYCLES=4, LOAD_CYCLES=2.
// Directed stimulus. Each scenario records outputs per cycle, with tick t
// being the t-th rising edge after the stimulus change. The recorded values
// are then compared against hand-computed expectations. With these
// parameters a press applied before tick 1 gives the event at tick 5,
// SETUP at 7, STROBE at 8-9, HOLD at 10 and IDLE at 11.
module tb_panel_selector;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] btn_a;
  logic [5:0] btn_b;
  logic       remote;
  logic [5:0] o_a;
  logic [5:0] o_b;
  logic       o_load;
  logic       o_coll;
  logic       o_busy;

  int total = 0;
  int bad   = 0;

  logic [5:0]  rec_a [0:31];
  logic [5:0]  rec_b [0:31];
  logic [31:0] rec_load;
  logic [31:0] rec_coll;
  logic [31:0] rec_busy;
  logic [5:0]  exp_sel_a;

  panel_selector #(.DEBOUNCE_CYCLES(4), .LOAD_CYCLES(2)) dut (
    .I_clk(clk), .I_rst(rst), .I_btn_A(btn_a), .I_btn_B(btn_b),
    .I_remote(remote), .O_A(o_a), .O_B(o_b), .O_load(o_load),
    .O_collision(o_coll), .O_busy(o_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic run_rec(input int n);
    rec_load = 32'd0;
    rec_coll = 32'd0;
    rec_busy = 32'd0;
    for (int t = 1; t <= n; t++) begin
      tick();
      rec_a[t]    = o_a;
      rec_b[t]    = o_b;
      rec_load[t] = o_load;
      rec_coll[t] = o_coll;
      rec_busy[t] = o_busy;
    end
  endtask

  initial begin
    rst = 1'b1; btn_a = 6'd0; btn_b = 6'd0; remote = 1'b0;
    wait_cycles(3);
    chk("rst_A", {26'd0, o_a}, 32'd0);
    chk("rst_B", {26'd0, o_b}, 32'd0);
    chk("rst_load", {31'd0, o_load}, 32'd0);
    chk("rst_coll", {31'd0, o_coll}, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    rst = 1'b0;
    wait_cycles(2);

    // Press A button 2.
    btn_a = 6'b000100;
    run_rec(14);
    chk("a2_busy_pre", {31'd0, rec_busy[6]}, 32'd0);
    chk("a2_busy_setup", {31'd0, rec_busy[7]}, 32'd1);
    chk("a2_A_setup", {26'd0, rec_a[7]}, 32'h04);
    chk("a2_load_setup", {31'd0, rec_load[7]}, 32'd0);
    chk("a2_load_t8", {31'd0, rec_load[8]}, 32'd1);
    chk("a2_load_t9", {31'd0, rec_load[9]}, 32'd1);
    chk("a2_load_hold", {31'd0, rec_load[10]}, 32'd0);
    chk("a2_A_hold", {26'd0, rec_a[10]}, 32'h04);
    chk("a2_load_cnt", $countones(rec_load), 32'd2);
    chk("a2_coll_cnt", $countones(rec_coll), 32'd0);
    chk("a2_A_idle", {26'd0, rec_a[14]}, 32'h04);
    chk("a2_busy_idle", {31'd0, rec_busy[11]}, 32'd0);
    btn_a = 6'd0;
    wait_cycles(10);

    // Two-cycle glitch on B button 0 is filtered.
    btn_b = 6'b000001;
    wait_cycles(2);
    btn_b = 6'd0;
    run_rec(14);
    chk("glitch_load_cnt", $countones(rec_load), 32'd0);
    chk("glitch_busy_cnt", $countones(rec_busy), 32'd0);
    chk("glitch_B", {26'd0, rec_b[14]}, 32'd0);

    // B button 2 collides with A on antenna 2 and is not committed.
    btn_b = 6'b000100;
    run_rec(14);
    chk("coll_B_setup", {26'd0, rec_b[7]}, 32'h04);
    chk("coll_pre", {31'd0, rec_coll[6]}, 32'd0);
    chk("coll_setup", {31'd0, rec_coll[7]}, 32'd1);
    chk("coll_hold", {31'd0, rec_coll[10]}, 32'd1);
    chk("coll_cnt", $countones(rec_coll), 32'd4);
    chk("coll_load_cnt", $countones(rec_load), 32'd2);
    chk("coll_B_idle", {26'd0, rec_b[11]}, 32'd0);
    chk("coll_A_idle", {26'd0, rec_a[11]}, 32'h04);
    btn_b = 6'd0;
    wait_cycles(10);

    // Simultaneous A button 1 and B button 3 produce two sequences, A first.
    btn_a = 6'b000010;
    btn_b = 6'b001000;
    run_rec(20);
    chk("dual_A_first", {26'd0, rec_a[7]}, 32'h02);
    chk("dual_B_first", {26'd0, rec_b[7]}, 32'd0);
    chk("dual_gap_busy", {31'd0, rec_busy[11]}, 32'd0);
    chk("dual_gap_load", {31'd0, rec_load[11]}, 32'd0);
    chk("dual_B_second", {26'd0, rec_b[12]}, 32'h08);
    chk("dual_A_second", {26'd0, rec_a[12]}, 32'h02);
    chk("dual_load_cnt", $countones(rec_load), 32'd4);
    chk("dual_coll_cnt", $countones(rec_coll), 32'd0);
    chk("dual_A_final", {26'd0, rec_a[20]}, 32'h02);
    chk("dual_B_final", {26'd0, rec_b[20]}, 32'h08);
    btn_a = 6'd0;
    btn_b = 6'd0;
    wait_cycles(10);

    // Re-press A button 1 while it is selected.
    btn_a = 6'b000010;
    run_rec(14);
`ifdef PANEL_DESELECT_EN
    exp_sel_a = 6'd0;
    chk("desel_load_cnt", $countones(rec_load), 32'd2);
    chk("desel_A_setup", {26'd0, rec_a[7]}, 32'd0);
`else
    exp_sel_a = 6'b000010;
    chk("desel_load_cnt", $countones(rec_load), 32'd0);
    chk("desel_busy_cnt", $countones(rec_busy), 32'd0);
`endif
    chk("desel_A_final", {26'd0, rec_a[14]}, {26'd0, exp_sel_a});
    btn_a = 6'd0;
    wait_cycles(10);

    // Remote mode discards the press of A button 5.
    remote = 1'b1;
    btn_a = 6'b100000;
    run_rec(14);
    chk("remote_busy_cnt", $countones(rec_busy), 32'd0);
    chk("remote_load_cnt", $countones(rec_load), 32'd0);
    chk("remote_A", {26'd0, rec_a[14]}, {26'd0, exp_sel_a});
    btn_a = 6'd0;
    wait_cycles(10);
    remote = 1'b0;
    wait_cycles(2);

    // Reset during STROBE clears everything on the next cycle.
    btn_a = 6'b001000;
    run_rec(8);
    chk("mid_load_t8", {31'd0, rec_load[8]}, 32'd1);
    chk("mid_A_t8", {26'd0, rec_a[8]}, 32'h08);
    rst = 1'b1;
    tick();
    chk("mid_rst_load", {31'd0, o_load}, 32'd0);
    chk("mid_rst_A", {26'd0, o_a}, 32'd0);
    chk("mid_rst_B", {26'd0, o_b}, 32'd0);
    chk("mid_rst_busy", {31'd0, o_busy}, 32'd0);
    rst = 1'b0;
    btn_a = 6'd0;
    wait_cycles(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
